imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_word_asm.sv | 34 +++
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the fixed byte counts that frame a program stream.
package imem_loader_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR0 = 3'd1;
  localparam logic [2:0] ST_HDR1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  // Stream framing: little-endian 16-bit word count, then one XOR checksum byte.
  localparam int HDR_BYTES = 2;
  localparam int CHK_BYTES = 1;

  typedef logic [15:0] wcnt_t;

endpackage

// File: rtl/imem_loader_word_asm.sv
// Assembles four consecutive stream bytes into one little-endian 32-bit word.
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_data,
  output logic        word_vld,
  output logic [31:0] word
);

  logic [23:0] sr;
  logic [1:0]  lane;

  // Bytes enter at the top, so after three shifts sr holds {b2,b1,b0}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      lane <= '0;
    end else if (clr) begin
      sr   <= '0;
      lane <= '0;
    end else if (en) begin
      sr   <= {byte_data, sr[23:8]};
      lane <= lane + 2'd1;
    end
  end

  assign word_vld = en && (lane == 2'd3);
  assign word     = {byte_data, sr};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory
// and holds the core in reset until the image is verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  logic [2:0]  state;
  logic [7:0]  n_lo;
  logic [7:0]  acc;
  wcnt_t       wcnt;
  wcnt_t       nwords;
  wcnt_t       n_hdr;
  logic        xfer;
  logic        take_start;
  logic        word_vld;
  logic [31:0] word;

  assign byte_ready = (state == ST_HDR0) || (state == ST_HDR1) ||
                      (state == ST_DATA) || (state == ST_CHK);
  assign xfer       = byte_valid && byte_ready;
  assign take_start = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                (state == ST_ERR));
  assign n_hdr      = {byte_data, n_lo};

  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERR);
  assign cpu_hold = (state != ST_DONE);

  loader_word_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (take_start),
    .en        (xfer && (state == ST_DATA)),
    .byte_data (byte_data),
    .word_vld  (word_vld),
    .word      (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      n_lo     <= '0;
      nwords   <= '0;
      acc      <= '0;
      wcnt     <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      // Write strobe lands the cycle after the fourth byte of each word.
      im_we <= word_vld;
      if (word_vld) begin
        im_addr  <= {14'd0, wcnt, 2'b00};
        im_wdata <= word;
        wcnt     <= wcnt + 16'd1;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state <= ST_HDR0;
            acc   <= '0;
            wcnt  <= '0;
          end
        end
        ST_HDR0: begin
          if (xfer) begin
            n_lo  <= byte_data;
            state <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (xfer) begin
            nwords <= n_hdr;
            if (n_hdr == 16'd0)
              state <= ST_CHK;
            else if (n_hdr > 16'(IMEM_WORDS))
              state <= ST_ERR;
            else
              state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer)
            acc <= acc ^ byte_data;
          if (word_vld && ((wcnt + 16'd1) == nwords))
            state <= ST_CHK;
        end
        ST_CHK: begin
          if (xfer)
            state <= (byte_data == acc) ? ST_DONE : ST_ERR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a stream-level model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  stream[$];
  logic [31:0] words[$];
  logic [7:0]  model_xor;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  imem_loader #(.IMEM_WORDS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory-side observer: every strobed write is logged with its cycle.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Builds header, little-endian payload and XOR checksum from words[].
  task automatic build(input int n);
    logic [15:0] nn;
    nn = 16'(n);
    stream = {};
    model_xor = 8'h00;
    for (int i = 0; i < HDR_BYTES; i++) stream.push_back(nn[8*i +: 8]);
    for (int k = 0; k < words.size(); k++) begin
      for (int b = 0; b < 4; b++) begin
        stream.push_back(words[k][8*b +: 8]);
        model_xor = model_xor ^ words[k][8*b +: 8];
      end
    end
    for (int i = 0; i < CHK_BYTES; i++) stream.push_back(model_xor);
  endtask

  task automatic rand_words(input int n);
    words = {};
    for (int k = 0; k < n; k++) words.push_back($urandom);
  endtask

  task automatic clear_log();
    wa = {};
    wd = {};
    wc = {};
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers the first nb stream bytes; rv randomizes byte_valid, rs sprinkles start pulses.
  task automatic send(input int nb, input bit rv, input bit rs);
    int idx;
    int budget;
    bit rdy;
    idx = 0;
    budget = nb * 30 + 50;
    while (idx < nb) begin
      @(negedge clk);
      byte_valid = rv ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_data  = byte_valid ? stream[idx] : 8'($urandom);
      start      = rs && ($urandom_range(0, 5) == 0);
      rdy        = byte_ready;
      @(posedge clk);
      if (byte_valid && rdy) idx++;
      budget--;
      if (budget == 0) begin
        chk("send_timeout", idx, nb);
        break;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    #1;
  endtask

  task automatic check_writes(input int n);
    chk("wr_count", wa.size(), n);
    for (int k = 0; k < n && k < wa.size(); k++) begin
      chk($sformatf("wr_addr[%0d]", k), wa[k], 32'(4 * k));
      chk($sformatf("wr_data[%0d]", k), wd[k], words[k]);
    end
  endtask

  task automatic check_end(input bit exp_done);
    chk("done", done, exp_done);
    chk("error", error, !exp_done);
    chk("cpu_hold", cpu_hold, !exp_done);
    chk("byte_ready_end", byte_ready, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, byte_ready, 1'b0);
    chk({tag, "_im_we"}, im_we, 1'b0);
    chk({tag, "_im_addr"}, im_addr, 32'h0);
    chk({tag, "_im_wdata"}, im_wdata, 32'h0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    int n;
    bit bad;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;

    // Two-word program, continuous stream, good checksum.
    clear_log();
    words = {32'h00002083, 32'h00100193};
    build(2);
    start_load();
    send(stream.size(), 1'b0, 1'b0);
    check_writes(2);
    if (wc.size() == 2) chk("no_bubble", wc[1] - wc[0], 4);
    check_end(1'b1);
    chk("hold_addr", im_addr, 32'h4);
    chk("hold_wdata", im_wdata, 32'h00100193);

    // Same program with a wrong checksum byte.
    clear_log();
    build(2);
    stream[stream.size() - 1] = 8'h23;
    start_load();
    send(stream.size(), 1'b0, 1'b0);
    check_writes(2);
    check_end(1'b0);

    // Oversized header: rejected right after the second header byte.
    clear_log();
    stream = {8'h21, 8'h00};
    start_load();
    send(2, 1'b0, 1'b0);
    chk("ovf_writes", wa.size(), 0);
    check_end(1'b0);

    // Empty program: no writes, core released.
    clear_log();
    words = {};
    build(0);
    start_load();
    send(stream.size(), 1'b0, 1'b0);
    chk("empty_writes", wa.size(), 0);
    check_end(1'b1);

    // Full-depth load with throttled valid and stray start pulses.
    clear_log();
    rand_words(32);
    build(32);
    start_load();
    send(stream.size(), 1'b1, 1'b1);
    check_writes(32);
    if (wa.size() == 32) chk("last_addr", wa[31], 32'h7C);
    check_end(1'b1);

    // Reset after five payload bytes aborts, keeping only the first word.
    clear_log();
    rand_words(2);
    build(2);
    start_load();
    send(HDR_BYTES + 5, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check_writes(1);
    chk("after_rst_hold", cpu_hold, 1'b1);

    // Restart after the abort completes normally.
    clear_log();
    start_load();
    send(stream.size(), 1'b1, 1'b0);
    check_writes(2);
    check_end(1'b1);

    // Random lengths with random checksum corruption.
    for (int it = 0; it < 4; it++) begin
      clear_log();
      n = $urandom_range(1, 8);
      bad = $urandom_range(0, 1);
      rand_words(n);
      build(n);
      if (bad) stream[stream.size() - 1] = model_xor ^ 8'(1 << $urandom_range(0, 7));
      start_load();
      send(stream.size(), 1'b1, 1'b1);
      check_writes(n);
      check_end(!bad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
